// File: rtl/factorial_core_pkg.sv
// Shared constants for the factorial accelerator: register offsets, FSM encoding, widths.
// Also imported by the bus-side master so both agree on the register map.
package factorial_core_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned OFS_W    = 4;
    localparam int unsigned RES_W    = 64;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned STEP_W   = $clog2(CNT_W);

    localparam logic [OFS_W-1:0] OFS_OPSTART  = 4'h0;
    localparam logic [OFS_W-1:0] OFS_OPCLEAR  = 4'h1;
    localparam logic [OFS_W-1:0] OFS_OPERAND  = 4'h2;
    localparam logic [OFS_W-1:0] OFS_RESULT_H = 4'h3;
    localparam logic [OFS_W-1:0] OFS_RESULT_L = 4'h4;
    localparam logic [OFS_W-1:0] OFS_INTR_EN  = 4'h5;
    localparam logic [OFS_W-1:0] OFS_STATUS   = 4'h6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_MUL  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } fsm_state_e;

    typedef struct packed {
        logic              sel;
        logic              wr;
        logic [OFS_W-1:0]  ofs;
        logic [DATA_W-1:0] din;
    } bus_req_t;

    function automatic logic is_busy(input fsm_state_e s);
        return (s == ST_INIT) || (s == ST_MUL) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/factorial_core_multiplier.sv
// Sequential 64x32 shift-add multiplier; the start edge performs the first partial step,
// so a product is ready 32 cycles after start. Output truncated to 64 bits.
module factorial_core_multiplier
    import factorial_core_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clear,
    input  logic [RES_W-1:0] multiplicand,
    input  logic [CNT_W-1:0] multiplier,
    output logic [RES_W-1:0] product,
    output logic             done
);

    logic [RES_W-1:0]  mcand;
    logic [CNT_W-1:0]  mplier;
    logic [RES_W-1:0]  acc;
    logic [STEP_W-1:0] steps;
    logic              running;
    logic [RES_W-1:0]  acc_sum_c;

    always_comb begin
        acc_sum_c = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            steps   <= '0;
            running <= 1'b0;
            product <= '0;
            done    <= 1'b0;
        end else if (clear) begin
            running <= 1'b0;
            steps   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc     <= multiplier[0] ? multiplicand : '0;
                mcand   <= multiplicand << 1;
                mplier  <= multiplier >> 1;
                steps   <= STEP_W'(CNT_W - 1);
                running <= 1'b1;
            end else if (running) begin
                acc    <= acc_sum_c;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                steps  <= steps - STEP_W'(1);
                if (steps == STEP_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                    product <= acc_sum_c;
                end
            end
        end
    end

endmodule

// File: rtl/factorial_core.sv
// Bus-mapped factorial accelerator: register file, control FSM and one shared multiplier.
// Result is N! modulo 2^64; status reads reflect the state before the sampling edge.
module factorial_core
    import factorial_core_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [ADDR_W-1:0] S_address,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout,
    output logic              interrupt
);

    fsm_state_e        state;
    logic [CNT_W-1:0]  operand;
    logic [CNT_W-1:0]  counter;
    logic [RES_W-1:0]  result;
    logic              intr_en;
    logic              mul_start;
    logic [RES_W-1:0]  mul_product;
    logic              mul_done;

    bus_req_t          req_c;
    logic              wr_c;
    logic              rd_c;
    logic              start_c;
    logic              clear_c;
    logic              busy_c;
    logic              done_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              unused_addr_c;

    always_comb begin
        req_c.sel = S_sel;
        req_c.wr  = S_wr;
        req_c.ofs = S_address[OFS_W-1:0];
        req_c.din = S_din;
    end

    assign unused_addr_c = ^S_address[ADDR_W-1:OFS_W];

    always_comb begin
        wr_c    = req_c.sel && req_c.wr;
        rd_c    = req_c.sel && !req_c.wr;
        start_c = wr_c && (req_c.ofs == OFS_OPSTART) && req_c.din[0];
        clear_c = wr_c && (req_c.ofs == OFS_OPCLEAR) && req_c.din[0];
        busy_c  = is_busy(state);
        done_c  = (state == ST_DONE);
    end

    // Read mux; write-only and unmapped offsets read as zero.
    always_comb begin
        rd_data_c = '0;
        case (req_c.ofs)
            OFS_OPERAND:  rd_data_c = operand;
            OFS_RESULT_H: rd_data_c = result[RES_W-1:DATA_W];
            OFS_RESULT_L: rd_data_c = result[DATA_W-1:0];
            OFS_INTR_EN:  rd_data_c = DATA_W'(intr_en);
            OFS_STATUS:   rd_data_c = DATA_W'({busy_c, done_c});
            default:      rd_data_c = '0;
        endcase
    end

    // Both operands are flops, so the interrupt carries no path from the bus inputs.
    assign interrupt = intr_en && done_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            operand   <= '0;
            counter   <= '0;
            result    <= '0;
            intr_en   <= 1'b0;
            mul_start <= 1'b0;
            S_dout    <= '0;
        end else begin
            S_dout    <= rd_c ? rd_data_c : '0;
            mul_start <= 1'b0;
            if (wr_c && (req_c.ofs == OFS_INTR_EN)) begin
                intr_en <= req_c.din[0];
            end
            if (wr_c && (req_c.ofs == OFS_OPERAND) && !busy_c) begin
                operand <= req_c.din;
            end
            if (clear_c) begin
                state  <= ST_IDLE;
                result <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_c) state <= ST_INIT;
                    end
                    ST_INIT: begin
                        result  <= RES_W'(1);
                        counter <= operand;
                        if (operand > CNT_W'(1)) begin
                            state     <= ST_MUL;
                            mul_start <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                    ST_MUL: begin
                        if (mul_done) state <= ST_STEP;
                    end
                    ST_STEP: begin
                        result  <= mul_product;
                        counter <= counter - CNT_W'(1);
                        // New counter is counter-1; keep multiplying while it exceeds 1.
                        if (counter > CNT_W'(2)) begin
                            state     <= ST_MUL;
                            mul_start <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    factorial_core_multiplier u_mul (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (mul_start),
        .clear        (clear_c),
        .multiplicand (result),
        .multiplier   (counter),
        .product      (mul_product),
        .done         (mul_done)
    );

endmodule
